// File: rtl/piso_tx_arbiter.sv
// Round-robin arbitrated parallel-in/serial-out transmitter: two requesters, framed MSB-first output.
// Optional macro PISO_TX_PARITY_EN appends an even-parity bit to every frame.
module piso_tx_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_src,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_TX_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             ser_src_q, ser_src_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             grant_a, grant_b;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // last_grant of 1 means B was served last, so A wins a tie.
  assign grant_a = req_a && (!req_b || last_grant_q);
  assign grant_b = req_b && (!req_a || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ser_src_d    = ser_src_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_a) begin
          shreg_d      = data_a;
          ser_src_d    = 1'b0;
          last_grant_d = 1'b0;
          cnt_d        = '0;
          ack_a_d      = 1'b1;
          state_d      = SHIFT;
`ifdef PISO_TX_PARITY_EN
          parity_d     = ^data_a;
`endif
        end else if (grant_b) begin
          shreg_d      = data_b;
          ser_src_d    = 1'b1;
          last_grant_d = 1'b1;
          cnt_d        = '0;
          ack_b_d      = 1'b1;
          state_d      = SHIFT;
`ifdef PISO_TX_PARITY_EN
          parity_d     = ^data_b;
`endif
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      ser_src_q    <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ser_src_q    <= ser_src_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
`ifdef PISO_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign ser_valid  = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign frame_done = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign ser_src    = ser_src_q;

  // The parity bit follows the data bits, once the word has shifted fully out.
`ifdef PISO_TX_PARITY_EN
  assign ser_out = (state_q == SHIFT) &&
                   ((cnt_q == LAST_CNT) ? parity_q : shreg_q[WIDTH-1]);
`else
  assign ser_out = (state_q == SHIFT) && shreg_q[WIDTH-1];
`endif

endmodule
